// File: rtl/display_sprites_axi_slave_if.sv
// AXI4-Lite channel bundle between the configuring master and the sprite register file.
// The master modport is the bus initiator; the slave modport is the register file.
interface display_sprites_axi_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
  logic [2:0]                        s00_axi_awprot;
  logic                              s00_axi_awvalid;
  logic                              s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb;
  logic                              s00_axi_wvalid;
  logic                              s00_axi_wready;
  logic [1:0]                        s00_axi_bresp;
  logic                              s00_axi_bvalid;
  logic                              s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
  logic [2:0]                        s00_axi_arprot;
  logic                              s00_axi_arvalid;
  logic                              s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
  logic [1:0]                        s00_axi_rresp;
  logic                              s00_axi_rvalid;
  logic                              s00_axi_rready;

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_rready,
    input  s00_axi_awready, s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_rready,
    output s00_axi_awready, s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );
endinterface

// File: rtl/display_sprites_axi_slave.sv
// AXI4-Lite register file for the sprite engine: four 32-bit registers, AW/W buffered
// independently, one outstanding write, per-register write pulse to the datapath.
module display_sprites_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  display_sprites_axi_slave_if.slave    s00_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
  output logic [3:0]                    reg_wr_pulse
);
  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam int NUM_REGS  = 4;

  logic                          aw_full_reg;
  logic [1:0]                    aw_sel_reg;
  logic                          w_full_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [NUM_BYTES-1:0]          w_strb_reg;
  logic                          bvalid_reg;
  logic                          rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_bank;
  logic [NUM_REGS-1:0]                         pulse_bank;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic unused_bits;

  // Ready depends on registered state only, never on the incoming valids.
  assign s00_axi.s00_axi_awready = !aw_full_reg && !bvalid_reg;
  assign s00_axi.s00_axi_wready  = !w_full_reg && !bvalid_reg;
  assign s00_axi.s00_axi_arready = !rvalid_reg;
  assign s00_axi.s00_axi_bvalid  = bvalid_reg;
  assign s00_axi.s00_axi_bresp   = 2'b00;
  assign s00_axi.s00_axi_rvalid  = rvalid_reg;
  assign s00_axi.s00_axi_rdata   = rdata_reg;
  assign s00_axi.s00_axi_rresp   = 2'b00;

  assign aw_hs  = s00_axi.s00_axi_awvalid && s00_axi.s00_axi_awready;
  assign w_hs   = s00_axi.s00_axi_wvalid && s00_axi.s00_axi_wready;
  assign ar_hs  = s00_axi.s00_axi_arvalid && s00_axi.s00_axi_arready;
  assign commit = aw_full_reg && w_full_reg && !bvalid_reg;

  assign unused_bits = ^{s00_axi.s00_axi_awprot, s00_axi.s00_axi_arprot,
                         s00_axi.s00_axi_awaddr[1:0], s00_axi.s00_axi_araddr[1:0]};

  // aw_hs/w_hs can never coincide with commit: ready is low while the buffer is full.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      aw_full_reg <= 1'b0;
      aw_sel_reg  <= 2'd0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
    end else begin
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
      end else if (bvalid_reg && s00_axi.s00_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_sel_reg  <= s00_axi.s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s00_axi.s00_axi_wdata;
        w_strb_reg <= s00_axi.s00_axi_wstrb;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [C_S_AXI_DATA_WIDTH-1:0] value_reg;
      logic                          pulse_reg;
      logic                          hit;

      assign hit = commit && (aw_sel_reg == 2'(gi));

      always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
          value_reg <= '0;
          pulse_reg <= 1'b0;
        end else begin
          // An all-zero strobe completes the write but is not a register update.
          pulse_reg <= hit && (|w_strb_reg);
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (hit && w_strb_reg[b]) begin
              value_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
            end
          end
        end
      end

      assign slv_bank[gi]   = value_reg;
      assign pulse_bank[gi] = pulse_reg;
    end
  endgenerate

  // Reads sample the pre-edge bank, so a same-edge commit returns the old value.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= slv_bank[s00_axi.s00_axi_araddr[3:2]];
    end else if (rvalid_reg && s00_axi.s00_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign slv_reg0     = slv_bank[0];
  assign slv_reg1     = slv_bank[1];
  assign slv_reg2     = slv_bank[2];
  assign slv_reg3     = slv_bank[3];
  assign reg_wr_pulse = pulse_bank;
endmodule

// File: tb/tb_display_sprites_axi_slave.sv
// Self-checking bench for display_sprites_axi_slave: scenario tasks with a read-data
// scoreboard and a bench-side register model.
module tb_display_sprites_axi_slave;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_reg[4];

  display_sprites_axi_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) ifc ();

  display_sprites_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi         (ifc),
    .slv_reg0        (slv_reg0),
    .slv_reg1        (slv_reg1),
    .slv_reg2        (slv_reg2),
    .slv_reg3        (slv_reg3),
    .reg_wr_pulse    (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slv_of(input int i);
    case (i)
      0: return slv_reg0;
      1: return slv_reg1;
      2: return slv_reg2;
      default: return slv_reg3;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Drives one write with per-channel start delays. lat counts cycles from the last
  // handshake to bvalid (-1 on timeout); b_after is bvalid one cycle later when bready is high.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, output int lat,
                          output logic [3:0] pulse, output logic [1:0] bresp, output logic b_after);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    ifc.s00_axi_awaddr = addr;
    ifc.s00_axi_wdata  = data;
    ifc.s00_axi_wstrb  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      ifc.s00_axi_awvalid = (cyc >= aw_delay) && !aw_done;
      ifc.s00_axi_wvalid  = (cyc >= w_delay) && !w_done;
      aw_hs = ifc.s00_axi_awvalid && ifc.s00_axi_awready;
      w_hs  = ifc.s00_axi_wvalid && ifc.s00_axi_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    ifc.s00_axi_awvalid = 1'b0;
    ifc.s00_axi_wvalid  = 1'b0;
    lat = 0;
    pulse = 4'hx;
    bresp = 2'bxx;
    b_after = 1'b1;
    if (aw_done && w_done) begin
      while (!ifc.s00_axi_bvalid && lat < 10) begin
        tick();
        lat++;
      end
      if (ifc.s00_axi_bvalid) begin
        pulse = reg_wr_pulse;
        bresp = ifc.s00_axi_bresp;
        if (ifc.s00_axi_bready) begin
          tick();
          b_after = ifc.s00_axi_bvalid;
        end
      end else begin
        lat = -1;
      end
    end else begin
      lat = -1;
    end
  endtask

  // Pushes the model value on AR and pops it when R appears; lat is cycles after the AR edge.
  task automatic do_read(input logic [3:0] addr, output int lat, output logic [31:0] got,
                         output logic [31:0] exp, output logic [1:0] rresp);
    int cyc = 0;
    exp_q.push_back(model_reg[addr[3:2]]);
    ifc.s00_axi_araddr  = addr;
    ifc.s00_axi_arvalid = 1'b1;
    while (!ifc.s00_axi_arready && cyc < 20) begin
      tick();
      cyc++;
    end
    lat = -1;
    got = 32'hx;
    rresp = 2'bxx;
    if (ifc.s00_axi_arready) begin
      tick();
      ifc.s00_axi_arvalid = 1'b0;
      lat = 0;
      while (!ifc.s00_axi_rvalid && lat < 10) begin
        tick();
        lat++;
      end
      if (ifc.s00_axi_rvalid) begin
        got = ifc.s00_axi_rdata;
        rresp = ifc.s00_axi_rresp;
        if (ifc.s00_axi_rready) tick();
      end else begin
        lat = -1;
      end
    end
    ifc.s00_axi_arvalid = 1'b0;
    exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ifc.s00_axi_bvalid, ifc.s00_axi_rvalid, reg_wr_pulse} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids: got bvalid=%b rvalid=%b pulse=%b required 0", ifc.s00_axi_bvalid, ifc.s00_axi_rvalid, reg_wr_pulse);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (slv_of(i) !== 32'h0) begin
        failures++;
        $display("FAIL reset_slv_reg%0d: got %h required 00000000", i, slv_of(i));
      end
    end
    checks++;
    if (ifc.s00_axi_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h required 00000000", ifc.s00_axi_rdata);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if ({ifc.s00_axi_awready, ifc.s00_axi_wready, ifc.s00_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_ready: got aw/w/ar=%b%b%b required 111", ifc.s00_axi_awready, ifc.s00_axi_wready, ifc.s00_axi_arready);
    end
    $display("test_reset done");
  endtask

  task automatic test_seq_write_read();
    int lat; logic [3:0] pulse; logic [1:0] resp; logic b_after; logic [31:0] got, exp;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, lat, pulse, resp, b_after);
      model_reg[i] = merge(model_reg[i], 32'(i + 1), 4'hF);
      $display("write addr=%h data=%h lat=%0d pulse=%b bresp=%b", i * 4, i + 1, lat, pulse, resp);
      checks++;
      if (lat !== 1 || b_after !== 1'b0) begin
        failures++;
        $display("FAIL seq_write_timing%0d: got lat=%0d b_after=%b required lat=1 b_after=0", i, lat, b_after);
      end
      checks++;
      if (pulse !== 4'(1 << i) || resp !== 2'b00) begin
        failures++;
        $display("FAIL seq_write_pulse%0d: got pulse=%b bresp=%b required pulse=%b bresp=00", i, pulse, resp, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), lat, got, exp, resp);
      $display("read addr=%h rdata=%h exp=%h lat=%0d rresp=%b", i * 4, got, exp, lat, resp);
      checks++;
      if (got !== exp || got !== 32'(i + 1) || resp !== 2'b00 || lat !== 0) begin
        failures++;
        $display("FAIL seq_read%0d: got %h rresp=%b lat=%0d required %h rresp=00 lat=0", i, got, resp, lat, 32'(i + 1));
      end
      checks++;
      if (ifc.s00_axi_arready !== 1'b1) begin
        failures++;
        $display("FAIL seq_read_arready%0d: got %b required 1", i, ifc.s00_axi_arready);
      end
    end
  endtask

  task automatic test_strobes();
    int lat; logic [3:0] pulse; logic [1:0] resp; logic b_after; logic [31:0] got, exp;
    do_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, lat, pulse, resp, b_after);
    model_reg[1] = merge(model_reg[1], 32'hFFFF_FFFF, 4'hF);
    do_write(4'h4, 32'h1234_5678, 4'b0101, 0, 0, lat, pulse, resp, b_after);
    model_reg[1] = merge(model_reg[1], 32'h1234_5678, 4'b0101);
    $display("write strb=0101 slv_reg1=%h pulse=%b", slv_reg1, pulse);
    checks++;
    if (slv_reg1 !== 32'hFF34_FF78 || pulse !== 4'b0010) begin
      failures++;
      $display("FAIL strobe_merge: got slv_reg1=%h pulse=%b required FF34FF78 0010", slv_reg1, pulse);
    end
    do_write(4'h4, 32'hDEAD_BEEF, 4'b0000, 0, 0, lat, pulse, resp, b_after);
    $display("write strb=0000 slv_reg1=%h pulse=%b lat=%0d", slv_reg1, pulse, lat);
    checks++;
    if (slv_reg1 !== 32'hFF34_FF78 || pulse !== 4'b0000 || lat !== 1 || resp !== 2'b00) begin
      failures++;
      $display("FAIL strobe_zero: got slv_reg1=%h pulse=%b lat=%0d bresp=%b required FF34FF78 0000 1 00", slv_reg1, pulse, lat, resp);
    end
    do_read(4'h4, lat, got, exp, resp);
    $display("read addr=4 rdata=%h exp=%h", got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL strobe_readback: got %h required %h", got, exp);
    end
  endtask

  task automatic test_ordering();
    int lat; logic [3:0] pulse; logic [1:0] resp; logic b_after;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] d;
      d = 32'hCAFE_0001 + 32'(k);
      do_write(4'hC, d, 4'hF, (k == 0) ? 3 : 0, (k == 0) ? 0 : 3, lat, pulse, resp, b_after);
      model_reg[3] = merge(model_reg[3], d, 4'hF);
      $display("write order=%s slv_reg3=%h lat=%0d b_after=%b", (k == 0) ? "W-first" : "AW-first", slv_reg3, lat, b_after);
      checks++;
      if (slv_reg3 !== model_reg[3] || lat !== 1 || b_after !== 1'b0 || pulse !== 4'b1000) begin
        failures++;
        $display("FAIL ordering%0d: got slv_reg3=%h lat=%0d b_after=%b pulse=%b required %h 1 0 1000", k, slv_reg3, lat, b_after, pulse, model_reg[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] pulse; logic [1:0] resp; logic b_after; logic [31:0] got, exp;
    ifc.s00_axi_bready = 1'b0;
    do_write(4'h0, 32'h0000_0077, 4'hF, 0, 0, lat, pulse, resp, b_after);
    model_reg[0] = merge(model_reg[0], 32'h0000_0077, 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ifc.s00_axi_bvalid, ifc.s00_axi_awready, ifc.s00_axi_wready} !== 3'b100) begin
        failures++;
        $display("FAIL b_stall%0d: got bvalid/awready/wready=%b%b%b required 100", i, ifc.s00_axi_bvalid, ifc.s00_axi_awready, ifc.s00_axi_wready);
      end
    end
    ifc.s00_axi_bready = 1'b1;
    tick();
    $display("b backpressure released bvalid=%b awready=%b", ifc.s00_axi_bvalid, ifc.s00_axi_awready);
    checks++;
    if (ifc.s00_axi_bvalid !== 1'b0 || ifc.s00_axi_awready !== 1'b1) begin
      failures++;
      $display("FAIL b_release: got bvalid=%b awready=%b required 0 1", ifc.s00_axi_bvalid, ifc.s00_axi_awready);
    end
    ifc.s00_axi_rready = 1'b0;
    do_read(4'h0, lat, got, exp, resp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL r_stall_data: got %h required %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.s00_axi_rvalid !== 1'b1 || ifc.s00_axi_rdata !== exp || ifc.s00_axi_arready !== 1'b0) begin
        failures++;
        $display("FAIL r_stall%0d: got rvalid=%b rdata=%h arready=%b required 1 %h 0", i, ifc.s00_axi_rvalid, ifc.s00_axi_rdata, ifc.s00_axi_arready, exp);
      end
    end
    ifc.s00_axi_rready = 1'b1;
    tick();
    $display("r backpressure released rvalid=%b", ifc.s00_axi_rvalid);
    checks++;
    if (ifc.s00_axi_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL r_release: got rvalid=%b required 0", ifc.s00_axi_rvalid);
    end
  endtask

  task automatic test_collision();
    int lat; logic [3:0] pulse; logic [1:0] resp; logic b_after; logic [31:0] got, exp;
    do_write(4'h8, 32'h0000_000A, 4'hF, 0, 0, lat, pulse, resp, b_after);
    model_reg[2] = merge(model_reg[2], 32'h0000_000A, 4'hF);
    ifc.s00_axi_awaddr = 4'h8;
    ifc.s00_axi_wdata = 32'h0000_000B;
    ifc.s00_axi_wstrb = 4'hF;
    ifc.s00_axi_awvalid = 1'b1;
    ifc.s00_axi_wvalid = 1'b1;
    tick();
    ifc.s00_axi_awvalid = 1'b0;
    ifc.s00_axi_wvalid = 1'b0;
    ifc.s00_axi_araddr = 4'h8;
    ifc.s00_axi_arvalid = 1'b1;
    exp_q.push_back(model_reg[2]);
    tick();
    ifc.s00_axi_arvalid = 1'b0;
    exp = exp_q.pop_front();
    $display("collision rdata=%h exp=%h slv_reg2=%h bvalid=%b", ifc.s00_axi_rdata, exp, slv_reg2, ifc.s00_axi_bvalid);
    checks++;
    if (ifc.s00_axi_rvalid !== 1'b1 || ifc.s00_axi_rdata !== exp) begin
      failures++;
      $display("FAIL collision_old: got rvalid=%b rdata=%h required 1 %h", ifc.s00_axi_rvalid, ifc.s00_axi_rdata, exp);
    end
    model_reg[2] = merge(model_reg[2], 32'h0000_000B, 4'hF);
    checks++;
    if (slv_reg2 !== model_reg[2] || ifc.s00_axi_bvalid !== 1'b1) begin
      failures++;
      $display("FAIL collision_commit: got slv_reg2=%h bvalid=%b required %h 1", slv_reg2, ifc.s00_axi_bvalid, model_reg[2]);
    end
    tick();
    do_read(4'h8, lat, got, exp, resp);
    $display("read addr=8 rdata=%h exp=%h", got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL collision_new: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [1:0] resp; logic [31:0] got, exp;
    ifc.s00_axi_rready = 1'b0;
    exp_q.push_back(model_reg[0]);
    ifc.s00_axi_araddr = 4'h0;
    ifc.s00_axi_arvalid = 1'b1;
    tick();
    ifc.s00_axi_arvalid = 1'b0;
    ifc.s00_axi_awaddr = 4'h4;
    ifc.s00_axi_awvalid = 1'b1;
    tick();
    ifc.s00_axi_awvalid = 1'b0;
    aresetn = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_reg[i] = 32'h0;
    $display("mid-op reset bvalid=%b rvalid=%b rdata=%h ready=%b%b%b", ifc.s00_axi_bvalid, ifc.s00_axi_rvalid, ifc.s00_axi_rdata, ifc.s00_axi_awready, ifc.s00_axi_wready, ifc.s00_axi_arready);
    checks++;
    if ({ifc.s00_axi_bvalid, ifc.s00_axi_rvalid, reg_wr_pulse} !== 6'b0 || ifc.s00_axi_rdata !== 32'h0
        || {ifc.s00_axi_awready, ifc.s00_axi_wready, ifc.s00_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL midreset_outputs: got bvalid=%b rvalid=%b rdata=%h ready=%b%b%b required 0 0 0 111", ifc.s00_axi_bvalid, ifc.s00_axi_rvalid, ifc.s00_axi_rdata, ifc.s00_axi_awready, ifc.s00_axi_wready, ifc.s00_axi_arready);
    end
    checks++;
    if ({slv_reg0, slv_reg1, slv_reg2, slv_reg3} !== 128'h0) begin
      failures++;
      $display("FAIL midreset_regs: got %h %h %h %h required all 0", slv_reg0, slv_reg1, slv_reg2, slv_reg3);
    end
    aresetn = 1'b1;
    ifc.s00_axi_rready = 1'b1;
    tick();
    do_read(4'h0, lat, got, exp, resp);
    $display("read after reset addr=0 rdata=%h exp=%h", got, exp);
    checks++;
    if (got !== exp || lat !== 0) begin
      failures++;
      $display("FAIL midreset_read: got %h lat=%0d required %h lat=0", got, lat, exp);
    end
    // A lone W must not pair with the AW that the reset discarded.
    ifc.s00_axi_wdata = 32'h5555_5555;
    ifc.s00_axi_wvalid = 1'b1;
    tick();
    ifc.s00_axi_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifc.s00_axi_bvalid !== 1'b0 || slv_reg1 !== 32'h0) begin
        failures++;
        $display("FAIL midreset_stray_b%0d: got bvalid=%b slv_reg1=%h required 0 0", i, ifc.s00_axi_bvalid, slv_reg1);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    ifc.s00_axi_awaddr = '0;
    ifc.s00_axi_awprot = '0;
    ifc.s00_axi_awvalid = 1'b0;
    ifc.s00_axi_wdata = '0;
    ifc.s00_axi_wstrb = '0;
    ifc.s00_axi_wvalid = 1'b0;
    ifc.s00_axi_bready = 1'b1;
    ifc.s00_axi_araddr = '0;
    ifc.s00_axi_arprot = '0;
    ifc.s00_axi_arvalid = 1'b0;
    ifc.s00_axi_rready = 1'b1;
    for (int i = 0; i < 4; i++) model_reg[i] = 32'h0;
    test_reset();
    test_seq_write_read();
    test_strobes();
    test_ordering();
    test_backpressure();
    test_collision();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
